prefix_sub_pipe: RTL and testbench

//   Pipelined parallel-prefix subtractor with borrow in/out: D = A - B - BI.

---
 rtl/prefix_sub_pipe.sv | 169 ++++++++++++++++
 tb/tb_prefix_sub_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_sub_pipe.sv
// prefix_sub_pipe
//   Pipelined Kogge-Stone subtractor computing D = A - B - BI as
//   A + ~B + ~BI. A bitwise propagate/generate stage feeds LEVELS
//   registered prefix levels, followed by an output register that forms the
//   difference, borrow out and signed overflow. Valid/ready handshakes on
//   both sides give full throughput, and pipeline bubbles collapse.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all pipeline state
//   in_valid   A/B/BI valid this cycle
//   in_ready   stage 0 can accept (transfer on in_valid & in_ready)
//   A, B       minuend, subtrahend (Width bits)
//   BI         borrow in
//   out_valid  D/BO/V valid
//   out_ready  consumer accepts (transfer on out_valid & out_ready)
//   D          difference modulo 2^Width
//   BO         borrow out, 1 iff A < B + BI (unsigned)
//   V          two's-complement overflow of A - B - BI

module prefix_sub_pipe #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             BI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] D,
  output logic             BO,
  output logic             V
);

  localparam int LEVELS = $clog2(Width);
  localparam int LAST   = LEVELS + 1;

  // Stage 0 .. LEVELS carry the prefix tree; stage LAST is the output register.
  logic [LAST:0]      vld_q, vld_d;
  logic [LAST:0]      go;

  logic [Width-1:0]   gen_q  [0:LEVELS];
  logic [Width-1:0]   gen_d  [0:LEVELS];
  logic [Width-1:0]   prp_q  [0:LEVELS];
  logic [Width-1:0]   prp_d  [0:LEVELS];
  logic [Width-1:0]   psum_q [0:LEVELS];
  logic [Width-1:0]   psum_d [0:LEVELS];
  logic [LEVELS:0]    cin_q, cin_d;
  logic [LEVELS:0]    amsb_q, amsb_d;
  logic [LEVELS:0]    bmsb_q, bmsb_d;

  logic [Width-1:0]   d_q, d_d;
  logic               bo_q, bo_d;
  logic               v_q, v_d;

  logic [Width-1:0]   carries;
  logic [Width-1:0]   diff;

  // A stage may load when it is empty or its current contents move on. The
  // chain only looks at stored valid bits and out_ready, so in_ready never
  // depends on in_valid.
  always_comb begin
    go       = '0;
    go[LAST] = !vld_q[LAST] | out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      go[k] = !vld_q[k] | go[k+1];
    end
  end

  assign in_ready  = go[0];
  assign out_valid = vld_q[LAST];
  assign D         = d_q;
  assign BO        = bo_q;
  assign V         = v_q;

  // Next-state for every stage. Data only moves when the upstream stage holds
  // a valid operand, so a stalled or empty stage keeps its contents bit-exact.
  always_comb begin
    vld_d   = vld_q;
    gen_d   = gen_q;
    prp_d   = prp_q;
    psum_d  = psum_q;
    cin_d   = cin_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    d_d     = d_q;
    bo_d    = bo_q;
    v_d     = v_q;
    carries = '0;
    diff    = '0;

    // Bitwise terms of A + ~B; the carry-in ~BI is folded into the bit-0
    // generate so the tree output G_i is directly the carry into bit i+1.
    if (go[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        gen_d[0]    = A & ~B;
        gen_d[0][0] = (A[0] & ~B[0]) | ((A[0] | ~B[0]) & ~BI);
        prp_d[0]    = A ^ ~B;
        psum_d[0]   = A ^ ~B;
        cin_d[0]    = ~BI;
        amsb_d[0]   = A[Width-1];
        bmsb_d[0]   = B[Width-1];
      end
    end

    // Kogge-Stone level k combines with the neighbour 2^(k-1) bits down.
    // Shifting in zeros for G and ones for P makes the low bits pass through.
    for (int k = 1; k <= LEVELS; k++) begin
      if (go[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          gen_d[k]  = gen_q[k-1] | (prp_q[k-1] & (gen_q[k-1] << (1 << (k-1))));
          prp_d[k]  = prp_q[k-1] & ~((~prp_q[k-1]) << (1 << (k-1)));
          psum_d[k] = psum_q[k-1];
          cin_d[k]  = cin_q[k-1];
          amsb_d[k] = amsb_q[k-1];
          bmsb_d[k] = bmsb_q[k-1];
        end
      end
    end

    // Final sum: c_0 = ~BI, c_{i+1} = G_i; the borrow is the inverted carry.
    if (go[LAST]) begin
      vld_d[LAST] = vld_q[LEVELS];
      if (vld_q[LEVELS]) begin
        carries = {gen_q[LEVELS][Width-2:0], cin_q[LEVELS]};
        diff    = psum_q[LEVELS] ^ carries;
        d_d     = diff;
        bo_d    = ~gen_q[LEVELS][Width-1];
        v_d     = (amsb_q[LEVELS] ^ bmsb_q[LEVELS]) & (diff[Width-1] ^ amsb_q[LEVELS]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      cin_q  <= '0;
      amsb_q <= '0;
      bmsb_q <= '0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      v_q    <= 1'b0;
      for (int k = 0; k <= LEVELS; k++) begin
        gen_q[k]  <= '0;
        prp_q[k]  <= '0;
        psum_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      cin_q  <= cin_d;
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      d_q    <= d_d;
      bo_q   <= bo_d;
      v_q    <= v_d;
      for (int k = 0; k <= LEVELS; k++) begin
        gen_q[k]  <= gen_d[k];
        prp_q[k]  <= prp_d[k];
        psum_q[k] <= psum_d[k];
      end
    end
  end

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// tb_prefix_sub_pipe
//   Bench for the 8-bit pipelined prefix subtractor. Known vectors from a
//   table plus random streams are pushed onto a scoreboard when accepted and
//   compared in order as results leave. Hand-written sequences cover output
//   stall, pipeline fill, mid-flight reset and first-result latency.

module tb_prefix_sub_pipe;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bi_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d_out;
  logic         bo_out;
  logic         v_out;

  prefix_sub_pipe #(.Width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .BI        (bi_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d_out),
    .BO        (bo_out),
    .V         (v_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    int           id;
  } exp_t;

  exp_t sb[$];
  exp_t pending;
  int   tests;
  int   fails;
  int   popped;
  int   run_len;
  int   max_run;
  int   next_id;

  // Reference: widen to W+1 bits so the borrow falls out as the top bit.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi, input int id);
    exp_t       e;
    logic [W:0] t;
    t    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.d  = t[W-1:0];
    e.bo = t[W];
    e.v  = (a[W-1] ^ b[W-1]) & (t[W-1] ^ a[W-1]);
    e.id = id;
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic bi, input exp_t e);
    in_valid = valid;
    a_in     = a;
    b_in     = b;
    bi_in    = bi;
    pending  = e;
  endtask

  task automatic checkOutput();
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_output: got D=0x%0h BO=%0b V=%0b, expected no result",
               d_out, bo_out, v_out);
    end else begin
      e = sb.pop_front();
      popped++;
      if ({d_out, bo_out, v_out} !== {e.d, e.bo, e.v}) begin
        fails++;
        $display("[TB] FAIL result_%0d: got D=0x%0h BO=%0b V=%0b, expected D=0x%0h BO=%0b V=%0b",
                 e.id, d_out, bo_out, v_out, e.d, e.bo, e.v);
      end
    end
  endtask

  // One cycle: sample both handshakes mid-cycle, then return just after the
  // next rising edge where new stimulus may be driven.
  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready) sb.push_back(pending);
    if (out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (out_valid && out_ready) begin
      checkOutput();
    end else if (out_valid && sb.size() > 0) begin
      tests++;
      if ({d_out, bo_out, v_out} !== {sb[0].d, sb[0].bo, sb[0].v}) begin
        fails++;
        $display("[TB] FAIL stall_hold_%0d: got D=0x%0h BO=%0b V=%0b, expected D=0x%0h BO=%0b V=%0b",
                 sb[0].id, d_out, bo_out, v_out, sb[0].d, sb[0].bo, sb[0].v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc;
    exp_t idle;
    idle = '{d: '0, bo: 1'b0, v: 1'b0, id: -1};
    applyStimulus(1'b0, '0, '0, 1'b0, idle);
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    checkVal("drain_empty", sb.size(), 0);
    sb.delete();
    // Extra idle cycles: any result now would be a duplicate or stale one.
    repeat (6) tick();
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    int   accepts;
    int   cyc;
    int   base;

    tests   = 0;
    fails   = 0;
    popped  = 0;
    run_len = 0;
    max_run = 0;
    next_id = 0;

    vecs[0] = '{a: 8'h05, b: 8'h03, bi: 1'b0, d: 8'h02, bo: 1'b0, v: 1'b0};
    vecs[1] = '{a: 8'h00, b: 8'h01, bi: 1'b0, d: 8'hFF, bo: 1'b1, v: 1'b0};
    vecs[2] = '{a: 8'h10, b: 8'h10, bi: 1'b1, d: 8'hFF, bo: 1'b1, v: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, bi: 1'b0, d: 8'h7F, bo: 1'b0, v: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'hFF, bi: 1'b0, d: 8'h80, bo: 1'b1, v: 1'b1};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, bi: 1'b1, d: 8'hFF, bo: 1'b1, v: 1'b0};
    vecs[6] = '{a: 8'h00, b: 8'h00, bi: 1'b0, d: 8'h00, bo: 1'b0, v: 1'b0};
    vecs[7] = '{a: 8'hFF, b: 8'h00, bi: 1'b1, d: 8'hFE, bo: 1'b0, v: 1'b0};

    e = '{d: '0, bo: 1'b0, v: 1'b0, id: -1};
    reset     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, e);

    // Reset state.
    #12;
    checkVal("reset_out_valid", out_valid, 0);
    checkVal("reset_D", d_out, 0);
    checkVal("reset_BO", bo_out, 0);
    checkVal("reset_V", v_out, 0);
    checkVal("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First operand alone: result appears LEVELS+1 = 4 cycles after accept.
    e = '{d: vecs[0].d, bo: vecs[0].bo, v: vecs[0].v, id: next_id++};
    applyStimulus(1'b1, vecs[0].a, vecs[0].b, vecs[0].bi, e);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, e);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    checkVal("first_latency", cyc, 4);
    drain();

    // Table vectors, back to back.
    for (int i = 0; i < 8; i++) begin
      e = '{d: vecs[i].d, bo: vecs[i].bo, v: vecs[i].v, id: next_id++};
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].bi, e);
      tick();
    end
    drain();

    // 20 random back-to-back operands must give 20 consecutive valid cycles.
    max_run = 0;
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbi;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      applyStimulus(1'b1, ra, rb, rbi, model(ra, rb, rbi, next_id++));
      tick();
    end
    drain();
    checkVal("stream_run", max_run, 20);

    // Output stalled for 10 cycles: five stages fill, then in_ready drops.
    out_ready = 1'b0;
    accepts   = 0;
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbi;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rbi = 1'($urandom);
      applyStimulus(1'b1, ra, rb, rbi, model(ra, rb, rbi, next_id));
      if (in_ready) begin
        accepts++;
        next_id++;
      end
      tick();
    end
    checkVal("stall_accepts", accepts, 5);
    checkVal("stall_in_ready", in_ready, 0);
    checkVal("stall_out_valid", out_valid, 1);
    base = popped;
    drain();
    checkVal("stall_released", popped - base, 5);

    // Reset with three operands in flight and the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      applyStimulus(1'b1, ra, rb, 1'b0, model(ra, rb, 1'b0, next_id++));
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, e);
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    checkVal("pre_reset_out_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    checkVal("async_reset_out_valid", out_valid, 0);
    checkVal("async_reset_D", d_out, 0);
    checkVal("async_reset_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    e = model(8'h05, 8'h03, 1'b0, next_id++);
    applyStimulus(1'b1, 8'h05, 8'h03, 1'b0, e);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, e);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    checkVal("post_reset_latency", cyc, 4);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
